conv_enc_213: RTL and testbench
===============================

// Module: conv_enc_213
// PURPOSE
//  Rate-1/2, K=3 (2,1,3) convolutional encoder; transmit-side counterpart of the (2,1,3) Viterbi decoder.
//  Accepts one information bit per handshake and emits one registered 2-bit code symbol per bit.
//  Appends K-1=2 zero tail bits per frame, so every frame ends in trellis state 0.
//  tx_sym/tx_valid connect directly to the decoder BMU Rx/le inputs.
// PARAMETERS
//  FRAME_LEN  16      information bits per frame; range 1 .. 2**CNT_W-1
//  CNT_W      8       width of the frame bit counter
//  G0         3'b111  generator for tx_sym[1]; bit2 taps u(n), bit1 taps u(n-1), bit0 taps u(n-2)
//  G1         3'b101  generator for tx_sym[0]; same tap order as G0
// PORTS
//  clock       in   1  system clock; all state updates on the rising edge
//  reset       in   1  synchronous, active-high reset
//  start       in   1  one-cycle pulse that opens a frame; honoured only in IDLE
//  in_bit      in   1  information bit
//  in_valid    in   1  in_bit is valid
//  in_ready    out  1  encoder accepts in_bit this cycle (combinational: high iff state==DATA)
//  tx_sym      out  2  code symbol {c0,c1}
//  tx_valid    out  1  tx_sym is valid this cycle (one-cycle strobe)
//  busy        out  1  high when state != IDLE
//  frame_done  out  1  one-cycle pulse on the cycle the last tail symbol is presented
//  err_mask    in   2  error-injection mask; port exists only when CONV_ERR_INJ_EN is defined
// BEHAVIOUR
//  Reset: state=IDLE, sr=2'b00, cnt=0, tail_cnt=0, tx_sym=2'b00, tx_valid=0, frame_done=0.
//   reset overrides all other inputs and aborts any frame in progress; no tail bits are emitted after it.
//  Encoder core:
//   v = {u, sr[1], sr[0]}, where sr[1]=u(n-1) and sr[0]=u(n-2).
//   c0 = ^(v & G0); c1 = ^(v & G1).
//   Each step sets sr <= {u, sr[1]}.
//  FSM:
//   IDLE: in_ready=0. On start=1: sr<=0, cnt<=0, go to DATA.
//   DATA: in_ready=1. Each cycle with in_valid=1 accepts u=in_bit and increments cnt.
//         Accepting the FRAME_LEN-th bit moves to TAIL with tail_cnt<=0.
//         in_valid=0 stalls the FSM with no symbol out; gaps of any length are allowed.
//   TAIL: in_ready=0. Encodes u=0 on each of 2 consecutive cycles, with no stall.
//         The second tail step returns to IDLE.
//  Output timing:
//   tx_sym/tx_valid are registered and appear 1 cycle after the accept or tail step.
//   tx_valid is 0 in every cycle that has no step.
//  Frame shape: exactly FRAME_LEN+2 symbols per frame; after the last tail step sr==2'b00.
//  frame_done is asserted together with tx_valid for the last tail symbol, i.e. the cycle after the FSM enters IDLE.
//  A start that arrives in the same cycle as that frame_done is honoured, because the FSM is already in IDLE.
//  Boundaries:
//   start while busy=1 is ignored.
//   in_valid outside DATA is ignored.
//   FRAME_LEN=1 gives DATA for a single accept, then TAIL.
//  cnt compares against FRAME_LEN-1 on accept; no wrap is possible within the legal parameter range.
// CONFIGURATION
//  CONV_ERR_INJ_EN defined:
//   adds input err_mask[1:0]; registered output is tx_sym <= {c0,c1} ^ err_mask, sampled on every step.
//   The internal state sr is never affected by err_mask.
//  CONV_ERR_INJ_EN undefined: err_mask port is absent; tx_sym <= {c0,c1}.
// TESTING
//  1. Reset, start, then bits 1,0,1,1 with FRAME_LEN=4 -> tx_sym 11,10,00,01 then tail 01,11.
//     frame_done is high with the 11 symbol; busy drops.
//  2. Same frame with in_valid low for 3 cycles between bits 2 and 3 -> identical symbol sequence.
//     No tx_valid during the gap; in_ready stays 1.
//  3. start pulsed in DATA and in TAIL -> ignored; symbol count stays FRAME_LEN+2; in_bit driven during TAIL is not consumed.
//  4. reset asserted mid-DATA after 2 bits, then a new frame with bits 1,1,1,1:
//     first symbol is 11 (sr cleared), then 01,10,10, tail 01,11.
//  5. FRAME_LEN=1, bit 1 -> symbols 11,10,11; back-to-back start on the frame_done cycle opens the next frame.
//  6. CONV_ERR_INJ_EN defined, err_mask=2'b01 on the first step only, bits 1,0,1,1
//     -> 10,10,00,01,01,11 (only the first symbol is flipped).

Source files
------------

// File: rtl/conv_enc_213.sv
// -----------------------------------------------------------------------------
// conv_enc_213
// Rate-1/2, constraint length 3, (2,1,3) convolutional encoder. One information
// bit is accepted per handshake and one registered 2-bit code symbol is emitted
// per bit. Every frame of FRAME_LEN bits is closed with two zero tail bits, so
// the trellis always ends in state 0 for the matching Viterbi decoder.
//
// Parameters:
//   FRAME_LEN  information bits per frame (1 .. 2**CNT_W-1)
//   CNT_W      width of the frame bit counter
//   G0         generator for tx_sym[1]; bit2=u(n), bit1=u(n-1), bit0=u(n-2)
//   G1         generator for tx_sym[0]; same tap order
//
// Ports:
//   clock       system clock, rising edge
//   reset       synchronous active-high reset (aborts any frame, no tail)
//   start       opens a frame; only honoured while idle
//   in_bit      information bit
//   in_valid    in_bit is valid
//   in_ready    high while the encoder takes data bits (DATA state)
//   tx_sym      registered code symbol {c0,c1}
//   tx_valid    one-cycle strobe qualifying tx_sym
//   busy        high whenever a frame is in progress
//   frame_done  pulses together with the last tail symbol
//   err_mask    XOR mask applied to tx_sym (only with CONV_ERR_INJ_EN)
//
// Build option: define CONV_ERR_INJ_EN to add the err_mask error-injection port.
// -----------------------------------------------------------------------------
module conv_enc_213 #(
    parameter int         FRAME_LEN = 16,
    parameter int         CNT_W     = 8,
    parameter logic [2:0] G0        = 3'b111,
    parameter logic [2:0] G1        = 3'b101
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       in_bit,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [1:0] tx_sym,
    output logic       tx_valid,
    output logic       busy,
    output logic       frame_done
`ifdef CONV_ERR_INJ_EN
    ,
    input  logic [1:0] err_mask
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DATA = 2'd1,
        S_TAIL = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

    state_t           state_reg, state_next;
    logic [1:0]       sr_reg, sr_next;           // sr[1]=u(n-1), sr[0]=u(n-2)
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             tail_cnt_reg, tail_cnt_next;
    logic [1:0]       tx_sym_reg;
    logic             tx_valid_reg;
    logic             frame_done_reg;

    logic             step;                      // an encoder step happens this cycle
    logic             u;                         // bit being encoded this cycle
    logic             last_tail;                 // this step is the final tail step
    logic [2:0]       v;
    logic [2:0]       tap0, tap1;
    logic [1:0]       code;

    // Encoder core: parity of the generator-selected taps.
    assign v = {u, sr_reg};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_taps
            assign tap0[gi] = v[gi] & G0[gi];
            assign tap1[gi] = v[gi] & G1[gi];
        end
    endgenerate

    assign code = {^tap0, ^tap1};

    always_comb begin
        state_next    = state_reg;
        sr_next       = sr_reg;
        cnt_next      = cnt_reg;
        tail_cnt_next = tail_cnt_reg;
        step          = 1'b0;
        u             = 1'b0;
        last_tail     = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    sr_next    = 2'b00;
                    cnt_next   = '0;
                    state_next = S_DATA;
                end
            end
            S_DATA: begin
                if (in_valid) begin
                    step     = 1'b1;
                    u        = in_bit;
                    sr_next  = {in_bit, sr_reg[1]};
                    cnt_next = cnt_reg + CNT_W'(1);
                    if (cnt_reg == LAST_IDX) begin
                        state_next    = S_TAIL;
                        tail_cnt_next = 1'b0;
                    end
                end
            end
            S_TAIL: begin
                // Tail steps never stall; u is forced to zero to flush sr.
                step          = 1'b1;
                u             = 1'b0;
                sr_next       = {1'b0, sr_reg[1]};
                tail_cnt_next = 1'b1;
                if (tail_cnt_reg) begin
                    state_next = S_IDLE;
                    last_tail  = 1'b1;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg      <= S_IDLE;
            sr_reg         <= 2'b00;
            cnt_reg        <= '0;
            tail_cnt_reg   <= 1'b0;
            tx_sym_reg     <= 2'b00;
            tx_valid_reg   <= 1'b0;
            frame_done_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            sr_reg         <= sr_next;
            cnt_reg        <= cnt_next;
            tail_cnt_reg   <= tail_cnt_next;
            tx_valid_reg   <= step;
            frame_done_reg <= last_tail;
            if (step) begin
`ifdef CONV_ERR_INJ_EN
                // Mask only corrupts the transmitted symbol, never sr.
                tx_sym_reg <= code ^ err_mask;
`else
                tx_sym_reg <= code;
`endif
            end
        end
    end

    assign in_ready   = (state_reg == S_DATA);
    assign busy       = (state_reg != S_IDLE);
    assign tx_sym     = tx_sym_reg;
    assign tx_valid   = tx_valid_reg;
    assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_conv_enc_213.sv
// -----------------------------------------------------------------------------
// tb_conv_enc_213
// Directed bench for conv_enc_213. Instance A uses FRAME_LEN=4, instance B uses
// FRAME_LEN=1. Emitted symbols are collected on the falling edge and compared
// with hand-computed sequences for generators 111/101.
// -----------------------------------------------------------------------------
module tb_conv_enc_213;

    logic       clock = 1'b0;
    logic       reset = 1'b1;

    logic       start_a = 1'b0, in_bit_a = 1'b0, in_valid_a = 1'b0;
    logic       in_ready_a, tx_valid_a, busy_a, frame_done_a;
    logic [1:0] tx_sym_a;

    logic       start_b = 1'b0, in_bit_b = 1'b0, in_valid_b = 1'b0;
    logic       in_ready_b, tx_valid_b, busy_b, frame_done_b;
    logic [1:0] tx_sym_b;

`ifdef CONV_ERR_INJ_EN
    logic [1:0] err_mask_a = 2'b00;
    logic [1:0] err_mask_b = 2'b00;
`endif

    int checks   = 0;
    int failures = 0;

    logic [1:0] sym_a[$];
    logic       done_a[$];
    logic [1:0] sym_b[$];
    logic       done_b[$];

    always #5 clock = ~clock;

    conv_enc_213 #(.FRAME_LEN(4)) dut_a (
        .clock      (clock),
        .reset      (reset),
        .start      (start_a),
        .in_bit     (in_bit_a),
        .in_valid   (in_valid_a),
        .in_ready   (in_ready_a),
        .tx_sym     (tx_sym_a),
        .tx_valid   (tx_valid_a),
        .busy       (busy_a),
        .frame_done (frame_done_a)
`ifdef CONV_ERR_INJ_EN
        ,
        .err_mask   (err_mask_a)
`endif
    );

    conv_enc_213 #(.FRAME_LEN(1)) dut_b (
        .clock      (clock),
        .reset      (reset),
        .start      (start_b),
        .in_bit     (in_bit_b),
        .in_valid   (in_valid_b),
        .in_ready   (in_ready_b),
        .tx_sym     (tx_sym_b),
        .tx_valid   (tx_valid_b),
        .busy       (busy_b),
        .frame_done (frame_done_b)
`ifdef CONV_ERR_INJ_EN
        ,
        .err_mask   (err_mask_b)
`endif
    );

    // Symbol capture, away from the active edge.
    always @(negedge clock) begin
        if (tx_valid_a) begin
            sym_a.push_back(tx_sym_a);
            done_a.push_back(frame_done_a);
        end
        if (tx_valid_b) begin
            sym_b.push_back(tx_sym_b);
            done_b.push_back(frame_done_b);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("ok   %s value=%0h", tag, got);
        end
    endtask

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic pulse_start_a();
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
    endtask

    task automatic send_a(input logic b);
        check("a_in_ready", {31'd0, in_ready_a}, 32'd1);
        in_bit_a   = b;
        in_valid_a = 1'b1;
        tick();
        in_valid_a = 1'b0;
    endtask

    task automatic wait_idle_a(input string tag);
        for (int i = 0; i < 40 && busy_a; i++) tick();
        check(tag, {31'd0, busy_a}, 32'd0);
        tick();
    endtask

    task automatic wait_idle_b(input string tag);
        for (int i = 0; i < 40 && busy_b; i++) tick();
        check(tag, {31'd0, busy_b}, 32'd0);
        tick();
    endtask

    task automatic clear_q();
        sym_a.delete();
        done_a.delete();
        sym_b.delete();
        done_b.delete();
    endtask

    // Compare a captured 6-symbol frame sequence and its frame_done flags.
    task automatic check_seq(input string tag, input bit sel,
                             input logic [1:0] e[6], input logic [5:0] done_exp);
        logic [1:0] q[$];
        logic       d[$];
        logic [5:0] dv;
        if (sel) begin q = sym_b; d = done_b; end
        else     begin q = sym_a; d = done_a; end
        check($sformatf("%s_len", tag), q.size(), 32'd6);
        for (int i = 0; i < 6; i++)
            if (i < q.size())
                check($sformatf("%s_sym%0d", tag, i), {30'd0, q[i]}, {30'd0, e[i]});
        dv = '0;
        for (int i = 0; i < 6 && i < d.size(); i++) dv[i] = d[i];
        check($sformatf("%s_done", tag), {26'd0, dv}, {26'd0, done_exp});
    endtask

    logic [1:0] exp1[6];
    logic [1:0] exp4[6];
    logic [1:0] exp5[6];

    initial begin
        exp1 = '{2'b11, 2'b10, 2'b00, 2'b01, 2'b01, 2'b11};
        exp4 = '{2'b11, 2'b01, 2'b10, 2'b10, 2'b01, 2'b11};
        exp5 = '{2'b11, 2'b10, 2'b11, 2'b00, 2'b00, 2'b00};

        repeat (3) tick();
        reset = 1'b0;
        tick();

        // Reset state
        check("rst_tx_sym",     {30'd0, tx_sym_a},     32'd0);
        check("rst_tx_valid",   {31'd0, tx_valid_a},   32'd0);
        check("rst_busy",       {31'd0, busy_a},       32'd0);
        check("rst_frame_done", {31'd0, frame_done_a}, 32'd0);
        check("rst_in_ready",   {31'd0, in_ready_a},   32'd0);
        check("rst_b_busy",     {31'd0, busy_b},       32'd0);
        clear_q();

        // 1: basic frame 1,0,1,1
        pulse_start_a();
        check("t1_busy", {31'd0, busy_a}, 32'd1);
        send_a(1'b1); send_a(1'b0); send_a(1'b1); send_a(1'b1);
        check("t1_tail_ready", {31'd0, in_ready_a}, 32'd0);
        wait_idle_a("t1_idle");
        check_seq("t1", 1'b0, exp1, 6'b100000);
        clear_q();

        // 2: gap of 3 idle cycles between bits 2 and 3
        pulse_start_a();
        send_a(1'b1); send_a(1'b0);
        for (int k = 0; k < 3; k++) begin
            check("t2_gap_ready", {31'd0, in_ready_a}, 32'd1);
            if (k > 0) check("t2_gap_valid", {31'd0, tx_valid_a}, 32'd0);
            tick();
        end
        send_a(1'b1); send_a(1'b1);
        wait_idle_a("t2_idle");
        check_seq("t2", 1'b0, exp1, 6'b100000);
        clear_q();

        // 3: start in DATA and in TAIL ignored, in_bit in TAIL not consumed
        pulse_start_a();
        send_a(1'b1);
        start_a = 1'b1;
        send_a(1'b0);
        start_a = 1'b0;
        send_a(1'b1); send_a(1'b1);
        check("t3_tail_ready", {31'd0, in_ready_a}, 32'd0);
        start_a = 1'b1; in_valid_a = 1'b1; in_bit_a = 1'b1;
        tick();
        start_a = 1'b0;
        tick();
        in_valid_a = 1'b0;
        wait_idle_a("t3_idle");
        check_seq("t3", 1'b0, exp1, 6'b100000);
        repeat (3) tick();
        check("t3_no_restart", {31'd0, busy_a}, 32'd0);
        clear_q();

        // 4: reset mid-DATA, then 1,1,1,1
        pulse_start_a();
        send_a(1'b1); send_a(1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t4_rst_busy",  {31'd0, busy_a},     32'd0);
        check("t4_rst_valid", {31'd0, tx_valid_a}, 32'd0);
        clear_q();
        repeat (3) tick();
        check("t4_no_tail", sym_a.size(), 32'd0);
        pulse_start_a();
        send_a(1'b1); send_a(1'b1); send_a(1'b1); send_a(1'b1);
        wait_idle_a("t4_idle");
        check_seq("t4", 1'b0, exp4, 6'b100000);
        clear_q();

        // 5: FRAME_LEN=1, back-to-back start on frame_done
        start_b = 1'b1; tick(); start_b = 1'b0;
        check("t5_ready", {31'd0, in_ready_b}, 32'd1);
        in_bit_b = 1'b1; in_valid_b = 1'b1; tick(); in_valid_b = 1'b0;
        for (int i = 0; i < 20 && !frame_done_b; i++) tick();
        check("t5_done_seen", {31'd0, frame_done_b}, 32'd1);
        start_b = 1'b1; tick(); start_b = 1'b0;
        check("t5_restart_busy", {31'd0, busy_b}, 32'd1);
        in_bit_b = 1'b0; in_valid_b = 1'b1; tick(); in_valid_b = 1'b0;
        wait_idle_b("t5_idle");
        check_seq("t5", 1'b1, exp5, 6'b100100);
        clear_q();

`ifdef CONV_ERR_INJ_EN
        // 6: error injection on the first symbol only
        begin
            logic [1:0] exp6[6];
            exp6 = '{2'b10, 2'b10, 2'b00, 2'b01, 2'b01, 2'b11};
            pulse_start_a();
            err_mask_a = 2'b01;
            send_a(1'b1);
            err_mask_a = 2'b00;
            send_a(1'b0); send_a(1'b1); send_a(1'b1);
            wait_idle_a("t6_idle");
            check_seq("t6", 1'b0, exp6, 6'b100000);
            clear_q();
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
